// File: rtl/gtx_link_monitor_mc_pkg.sv
// gtx_link_monitor_mc_pkg: link FSM state encoding and parameter defaults shared by the link monitor.
package gtx_link_monitor_mc_pkg;

    typedef enum logic [1:0] {
        ST_DOWN  = 2'd0,
        ST_CHECK = 2'd1,
        ST_GOOD  = 2'd2,
        ST_BAD   = 2'd3
    } link_state_e;

    localparam int NCH_DEF         = 7;
    localparam int DW_DEF          = 48;
    localparam int DEPTH_DEF       = 16;
    localparam int CNTW_DEF        = 16;
    localparam int GOOD_FRAMES_DEF = 15;
    localparam int WIN_DEF         = 1024;
    localparam int BAD_THR_DEF     = 4;

endpackage

// File: rtl/gtx_link_chan.sv
// gtx_link_chan: one receiver channel - link FSM, error statistics, data mask and bx delay line.
//   clk_i, rst_ni          fabric clock, asynchronous active-low reset
//   resync_i               statistics clear pulse
//   ready_i, valid_i,
//   match_i, code_err_i    receiver status for this channel
//   data_i, delay_i        comparator data and delay tap select
//   data_o                 masked data delayed by 1 + delay_i cycles
//   good_o, bad_o          FSM is in GOOD / BAD
//   had_err_o, err_count_o sticky error flag and saturating error count
module gtx_link_chan
    import gtx_link_monitor_mc_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int CNTW        = CNTW_DEF,
    parameter int GOOD_FRAMES = GOOD_FRAMES_DEF,
    parameter int WIN         = WIN_DEF,
    parameter int BAD_THR     = BAD_THR_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       resync_i,
    input  logic                       ready_i,
    input  logic                       valid_i,
    input  logic                       match_i,
    input  logic                       code_err_i,
    input  logic [DW-1:0]              data_i,
    input  logic [$clog2(DEPTH)-1:0]   delay_i,
    output logic [DW-1:0]              data_o,
    output logic                       good_o,
    output logic                       bad_o,
    output logic                       had_err_o,
    output logic [CNTW-1:0]            err_count_o
);

    localparam int RUNW = $clog2(GOOD_FRAMES + 1);
    localparam int WCW  = $clog2(WIN);
    localparam int WEW  = $clog2(BAD_THR + 1);

    link_state_e     state_q, state_d;
    logic [RUNW-1:0] run_q, run_d;
    logic [WCW-1:0]  wc_q, wc_d;
    logic [WEW-1:0]  we_q, we_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            had_q, had_d;
    logic [DW-1:0]   tap_q [DEPTH-1];
    logic [DW-1:0]   line [DEPTH];
    logic [DW-1:0]   masked, data_q, data_d;
    logic            err, clean, frame, run_done, win_trip, wrap, in_check, in_good, count_en;

    assign err      = ready_i & (code_err_i | (valid_i & ~match_i));
    assign clean    = ready_i & valid_i & match_i & ~code_err_i;
    assign frame    = ready_i & valid_i;
    assign run_done = clean && run_q == RUNW'(GOOD_FRAMES - 1);
    assign win_trip = err && we_q == WEW'(BAD_THR - 1);
    assign wrap     = frame && wc_q == WCW'(WIN - 1);
    // Run and window counters only advance when neither a resync nor a ready drop overrides them
    assign in_check = state_q == ST_CHECK && ready_i && !resync_i;
    assign in_good  = state_q == ST_GOOD && ready_i && !resync_i;
    assign count_en = err && state_q != ST_DOWN;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_DOWN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_DOWN:  state_d = ST_CHECK;
            ST_CHECK: state_d = (in_check && run_done) ? ST_GOOD : ST_CHECK;
            ST_GOOD:  state_d = (in_good && win_trip) ? ST_BAD : ST_GOOD;
            ST_BAD:   state_d = resync_i ? ST_CHECK : ST_BAD;
        endcase
        // A ready drop wins over everything, including a coincident resync
        if (!ready_i) state_d = ST_DOWN;
    end

    always_comb begin
        good_o = state_q == ST_GOOD;
        bad_o  = state_q == ST_BAD;
        masked = state_q == ST_GOOD ? data_i : '0;
    end

    always_comb begin
        run_d  = (in_check && !err) ? run_q + RUNW'(clean) : '0;
        wc_d   = (!in_good || wrap) ? '0 : wc_q + WCW'(frame);
        // An error on the wrapping frame is judged against the closing window, then discarded
        we_d   = (!in_good || wrap) ? '0 : we_q + WEW'(err);
        cnt_d  = resync_i ? '0 : (count_en && cnt_q != '1) ? cnt_q + CNTW'(1) : cnt_q;
        had_d  = !resync_i && (had_q || count_en);
        line[0] = masked;
        for (int i = 1; i < DEPTH; i++) line[i] = tap_q[i-1];
        data_d = line[delay_i];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q <= '0;
            wc_q  <= '0;
            we_q  <= '0;
            cnt_q <= '0;
            had_q <= 1'b0;
        end else begin
            run_q <= run_d;
            wc_q  <= wc_d;
            we_q  <= we_d;
            cnt_q <= cnt_d;
            had_q <= had_d;
        end
    end

    // Free-running shift line; a delay change just selects another tap, stale contents included
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH - 1; i++) tap_q[i] <= '0;
            data_q <= '0;
        end else begin
            tap_q[0] <= masked;
            for (int i = 1; i < DEPTH - 1; i++) tap_q[i] <= tap_q[i-1];
            data_q <= data_d;
        end
    end

    assign data_o      = data_q;
    assign had_err_o   = had_q;
    assign err_count_o = cnt_q;

endmodule

// File: rtl/gtx_link_monitor_mc.sv
// gtx_link_monitor_mc: per-channel optical link health monitor with delayed, masked comparator data.
//   clock, reset_n         fabric clock, asynchronous active-low reset
//   ttc_resync             clears link statistics
//   rx_ready/valid/match/
//   rx_code_err, rx_data   per-channel receiver status and comparator data
//   delay_is               per-channel bx delay select
//   data_out               delayed, masked data
//   link_good, link_bad,
//   link_had_err, err_count per-channel link status and statistics
//   any_bad                OR of link_bad
module gtx_link_monitor_mc
    import gtx_link_monitor_mc_pkg::*;
#(
    parameter int NCH         = NCH_DEF,
    parameter int DW          = DW_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int CNTW        = CNTW_DEF,
    parameter int GOOD_FRAMES = GOOD_FRAMES_DEF,
    parameter int WIN         = WIN_DEF,
    parameter int BAD_THR     = BAD_THR_DEF
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          ttc_resync,
    input  logic [NCH-1:0]                rx_ready,
    input  logic [NCH-1:0]                rx_valid,
    input  logic [NCH-1:0]                rx_match,
    input  logic [NCH-1:0]                rx_code_err,
    input  logic [NCH*DW-1:0]             rx_data,
    input  logic [NCH*$clog2(DEPTH)-1:0]  delay_is,
    output logic [NCH*DW-1:0]             data_out,
    output logic [NCH-1:0]                link_good,
    output logic [NCH-1:0]                link_bad,
    output logic [NCH-1:0]                link_had_err,
    output logic [NCH*CNTW-1:0]           err_count,
    output logic                          any_bad
);

    localparam int DLYW = $clog2(DEPTH);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        gtx_link_chan #(
            .DW          (DW),
            .DEPTH       (DEPTH),
            .CNTW        (CNTW),
            .GOOD_FRAMES (GOOD_FRAMES),
            .WIN         (WIN),
            .BAD_THR     (BAD_THR)
        ) u_chan (
            .clk_i       (clock),
            .rst_ni      (reset_n),
            .resync_i    (ttc_resync),
            .ready_i     (rx_ready[c]),
            .valid_i     (rx_valid[c]),
            .match_i     (rx_match[c]),
            .code_err_i  (rx_code_err[c]),
            .data_i      (rx_data[c*DW +: DW]),
            .delay_i     (delay_is[c*DLYW +: DLYW]),
            .data_o      (data_out[c*DW +: DW]),
            .good_o      (link_good[c]),
            .bad_o       (link_bad[c]),
            .had_err_o   (link_had_err[c]),
            .err_count_o (err_count[c*CNTW +: CNTW])
        );
    end

    assign any_bad = |link_bad;

endmodule

// File: tb/tb_gtx_link_monitor_mc.sv
// tb_gtx_link_monitor_mc: scenario tasks checked against a frame-level link model.
module tb_gtx_link_monitor_mc;

    localparam int NCH = 7, DW = 48, DEPTH = 16, CNTW = 16, GOOD_FRAMES = 15, WIN = 1024, BAD_THR = 4;
    localparam int DLYW = $clog2(DEPTH);
    localparam int CMAX = (1 << CNTW) - 1;
    localparam int DOWN = 0, CHECK = 1, GOOD = 2, BAD = 3;

    logic                   clock = 1'b0, reset_n = 1'b0, ttc_resync = 1'b0;
    logic [NCH-1:0]         rx_ready = '0, rx_valid = '0, rx_match = '0, rx_code_err = '0;
    logic [NCH*DW-1:0]      rx_data = '0;
    logic [NCH*DLYW-1:0]    delay_is = '0;
    logic [NCH*DW-1:0]      data_out;
    logic [NCH-1:0]         link_good, link_bad, link_had_err;
    logic [NCH*CNTW-1:0]    err_count;
    logic                   any_bad;

    int n_checks = 0, n_fail = 0;
    int m_st [NCH], m_run [NCH], m_wc [NCH], m_we [NCH], m_ec [NCH];
    bit m_had [NCH];
    logic [NCH*DW-1:0] hist [$];
    logic [NCH*DW-1:0] exp_data;

    gtx_link_monitor_mc #(
        .NCH(NCH), .DW(DW), .DEPTH(DEPTH), .CNTW(CNTW),
        .GOOD_FRAMES(GOOD_FRAMES), .WIN(WIN), .BAD_THR(BAD_THR)
    ) dut (
        .clock(clock), .reset_n(reset_n), .ttc_resync(ttc_resync),
        .rx_ready(rx_ready), .rx_valid(rx_valid), .rx_match(rx_match), .rx_code_err(rx_code_err),
        .rx_data(rx_data), .delay_is(delay_is), .data_out(data_out),
        .link_good(link_good), .link_bad(link_bad), .link_had_err(link_had_err),
        .err_count(err_count), .any_bad(any_bad)
    );

    always #12 clock = ~clock;

    function automatic logic [3*NCH:0] exp_flags();
        logic [NCH-1:0] g, b, h;
        for (int c = 0; c < NCH; c++) begin
            g[c] = m_st[c] == GOOD;
            b[c] = m_st[c] == BAD;
            h[c] = m_had[c];
        end
        return {g, b, h, |b};
    endfunction

    function automatic logic [NCH*CNTW-1:0] exp_cnt();
        logic [NCH*CNTW-1:0] r;
        for (int c = 0; c < NCH; c++) r[c*CNTW +: CNTW] = CNTW'(m_ec[c]);
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_st[c] = DOWN; m_run[c] = 0; m_wc[c] = 0; m_we[c] = 0; m_ec[c] = 0; m_had[c] = 0;
        end
        hist.delete();
        for (int i = 0; i < DEPTH; i++) hist.push_back('0);
        exp_data = '0;
    endtask

    task automatic rand_data();
        logic [63:0] r;
        for (int c = 0; c < NCH; c++) begin
            r = {$urandom(), $urandom()};
            rx_data[c*DW +: DW] = r[DW-1:0];
        end
    endtask

    // Advance one clock: the model consumes this cycle's inputs, then outputs are sampled 1 unit after the edge
    task automatic tick();
        logic [NCH*DW-1:0] m;
        bit rdy, err, clean, frame;
        for (int c = 0; c < NCH; c++) m[c*DW +: DW] = m_st[c] == GOOD ? rx_data[c*DW +: DW] : '0;
        hist.push_front(m);
        void'(hist.pop_back());
        for (int c = 0; c < NCH; c++) exp_data[c*DW +: DW] = hist[delay_is[c*DLYW +: DLYW]][c*DW +: DW];
        for (int c = 0; c < NCH; c++) begin
            rdy   = rx_ready[c];
            err   = rdy && (rx_code_err[c] || (rx_valid[c] && !rx_match[c]));
            clean = rdy && rx_valid[c] && rx_match[c] && !rx_code_err[c];
            frame = rdy && rx_valid[c];
            if (ttc_resync) begin
                m_ec[c] = 0; m_had[c] = 0;
            end else if (err && m_st[c] != DOWN) begin
                if (m_ec[c] < CMAX) m_ec[c] = m_ec[c] + 1;
                m_had[c] = 1;
            end
            if (!rdy) begin
                m_st[c] = DOWN; m_run[c] = 0; m_wc[c] = 0; m_we[c] = 0;
            end else if (ttc_resync) begin
                m_run[c] = 0; m_wc[c] = 0; m_we[c] = 0;
                if (m_st[c] != GOOD) m_st[c] = CHECK;
            end else if (m_st[c] == DOWN) begin
                m_st[c] = CHECK;
            end else if (m_st[c] == CHECK) begin
                if (err) m_run[c] = 0;
                else if (clean) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == GOOD_FRAMES) begin
                        m_st[c] = GOOD; m_run[c] = 0; m_wc[c] = 0; m_we[c] = 0;
                    end
                end
            end else if (m_st[c] == GOOD) begin
                if (err && m_we[c] + 1 == BAD_THR) m_st[c] = BAD;
                else begin
                    m_we[c] = m_we[c] + int'(err);
                    if (frame) begin
                        m_wc[c] = m_wc[c] + 1;
                        if (m_wc[c] == WIN) begin m_wc[c] = 0; m_we[c] = 0; end
                    end
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({link_good, link_bad, link_had_err, any_bad} !== '0) begin
            n_fail++; $display("FAIL reset flags: got %h want 0", {link_good, link_bad, link_had_err, any_bad});
        end
        n_checks++;
        if (err_count !== '0) begin n_fail++; $display("FAIL reset err_count: got %h want 0", err_count); end
        n_checks++;
        if (data_out !== '0) begin n_fail++; $display("FAIL reset data_out: got %h want 0", data_out); end
        reset_n = 1'b1;
    endtask

    task automatic test_link_up();
        logic [NCH-1:0] want;
        for (int c = 0; c < NCH; c++) delay_is[c*DLYW +: DLYW] = DLYW'($urandom_range(0, DEPTH - 1));
        rx_ready = '1; rx_valid = '1; rx_match = '1; rx_code_err = '0;
        for (int i = 1; i <= 48; i++) begin
            rand_data();
            tick();
            if (i == 15 || i == 16) begin
                want = (i == 16) ? {NCH{1'b1}} : '0;
                n_checks++;
                if (link_good !== want) begin n_fail++; $display("FAIL link_up good at cycle %0d: got %b want %b", i, link_good, want); end
            end
            n_checks++;
            if ({link_good, link_bad, link_had_err, any_bad} !== exp_flags()) begin
                n_fail++; $display("FAIL link_up flags: got %h want %h", {link_good, link_bad, link_had_err, any_bad}, exp_flags());
            end
            n_checks++;
            if (data_out !== exp_data) begin n_fail++; $display("FAIL link_up data_out: got %h want %h", data_out, exp_data); end
        end
    endtask

    task automatic test_bad_link();
        logic [59:0] plan [NCH];
        int nerr [NCH];
        int cnt, p;
        logic [NCH-1:0] want_bad;
        delay_is = '0;
        for (int c = 0; c < NCH; c++) begin
            nerr[c] = (c % 2 == 0) ? BAD_THR : $urandom_range(0, BAD_THR - 1);
            want_bad[c] = nerr[c] == BAD_THR;
            plan[c] = '0;
            cnt = 0;
            while (cnt < nerr[c]) begin
                p = $urandom_range(0, 59);
                if (!plan[c][p]) begin plan[c][p] = 1'b1; cnt++; end
            end
        end
        for (int t = 0; t < 62; t++) begin
            for (int c = 0; c < NCH; c++) rx_match[c] = (t < 60) ? !plan[c][t] : 1'b1;
            rand_data();
            tick();
            n_checks++;
            if ({link_good, link_bad, link_had_err, any_bad} !== exp_flags()) begin
                n_fail++; $display("FAIL bad_link flags t=%0d: got %h want %h", t, {link_good, link_bad, link_had_err, any_bad}, exp_flags());
            end
            n_checks++;
            if (err_count !== exp_cnt()) begin n_fail++; $display("FAIL bad_link err_count: got %h want %h", err_count, exp_cnt()); end
            n_checks++;
            if (data_out !== exp_data) begin n_fail++; $display("FAIL bad_link data_out: got %h want %h", data_out, exp_data); end
        end
        n_checks++;
        if (link_bad !== want_bad) begin n_fail++; $display("FAIL bad_link link_bad: got %b want %b", link_bad, want_bad); end
        n_checks++;
        if (any_bad !== 1'b1) begin n_fail++; $display("FAIL bad_link any_bad: got %b want 1", any_bad); end
        for (int c = 0; c < NCH; c++) begin
            n_checks++;
            if (err_count[c*CNTW +: CNTW] !== CNTW'(nerr[c])) begin
                n_fail++; $display("FAIL bad_link count ch%0d: got %0d want %0d", c, err_count[c*CNTW +: CNTW], nerr[c]);
            end
            if (want_bad[c]) begin
                n_checks++;
                if (data_out[c*DW +: DW] !== '0) begin n_fail++; $display("FAIL bad_link mask ch%0d: got %h want 0", c, data_out[c*DW +: DW]); end
            end
        end
    endtask

    task automatic test_saturate();
        logic [NCH*CNTW-1:0] ones;
        for (int c = 0; c < NCH; c++) ones[c*CNTW +: CNTW] = CNTW'(1);
        rx_ready = '1; rx_valid = '1; rx_match = '0; rx_code_err = '0;
        repeat (70000) tick();
        n_checks++;
        if (err_count !== '1) begin n_fail++; $display("FAIL saturate err_count: got %h want all ones", err_count); end
        n_checks++;
        if (link_bad !== '1 || link_had_err !== '1) begin
            n_fail++; $display("FAIL saturate bad/had: got %b/%b want all ones", link_bad, link_had_err);
        end
        ttc_resync = 1'b1;
        tick();
        ttc_resync = 1'b0;
        n_checks++;
        if (err_count !== '0) begin n_fail++; $display("FAIL resync err_count: got %h want 0", err_count); end
        n_checks++;
        if ({link_good, link_bad, link_had_err, any_bad} !== '0) begin
            n_fail++; $display("FAIL resync flags: got %h want 0", {link_good, link_bad, link_had_err, any_bad});
        end
        tick();
        n_checks++;
        if (err_count !== ones) begin n_fail++; $display("FAIL post_resync err_count: got %h want %h", err_count, ones); end
        n_checks++;
        if ({link_good, link_bad, link_had_err, any_bad} !== exp_flags()) begin
            n_fail++; $display("FAIL post_resync flags: got %h want %h", {link_good, link_bad, link_had_err, any_bad}, exp_flags());
        end
    endtask

    task automatic test_resync_drop();
        rx_match = '1;
        repeat (GOOD_FRAMES) begin rand_data(); tick(); end
        n_checks++;
        if (link_good !== '1) begin n_fail++; $display("FAIL drop good: got %b want all ones", link_good); end
        rx_match = '0;
        repeat (BAD_THR) tick();
        n_checks++;
        if (link_bad !== '1 || any_bad !== 1'b1) begin n_fail++; $display("FAIL drop bad: got %b/%b want all ones", link_bad, any_bad); end
        rx_ready = '0; ttc_resync = 1'b1;
        tick();
        ttc_resync = 1'b0;
        n_checks++;
        if ({link_good, link_bad, link_had_err, any_bad} !== '0) begin
            n_fail++; $display("FAIL drop flags: got %h want 0", {link_good, link_bad, link_had_err, any_bad});
        end
        n_checks++;
        if (err_count !== '0) begin n_fail++; $display("FAIL drop err_count: got %h want 0", err_count); end
        rx_ready = '1; rx_match = '1;
        tick();
        n_checks++;
        if ({link_good, link_bad, link_had_err, any_bad} !== exp_flags()) begin
            n_fail++; $display("FAIL drop rearm flags: got %h want %h", {link_good, link_bad, link_had_err, any_bad}, exp_flags());
        end
    endtask

    task automatic test_window_wrap();
        logic [NCH*CNTW-1:0] sevens;
        for (int c = 0; c < NCH; c++) sevens[c*CNTW +: CNTW] = CNTW'(7);
        rx_match = '1;
        repeat (GOOD_FRAMES) begin rand_data(); tick(); end
        for (int f = 0; f < WIN + 3; f++) begin
            rx_match = (f < 3 || f >= WIN) ? '0 : '1;
            rand_data();
            tick();
        end
        n_checks++;
        if (link_good !== '1) begin n_fail++; $display("FAIL wrap still_good: got %b want all ones", link_good); end
        rx_match = '0;
        tick();
        rx_match = '1;
        n_checks++;
        if (link_bad !== '1) begin n_fail++; $display("FAIL wrap fourth_err: got %b want all ones", link_bad); end
        n_checks++;
        if (err_count !== sevens) begin n_fail++; $display("FAIL wrap err_count: got %h want %h", err_count, sevens); end
    endtask

    task automatic test_delay_sweep();
        int dl [3] = '{0, 15, 3};
        int lat;
        logic [DW-1:0] one;
        logic [NCH*DW-1:0] pulse;
        one = DW'(1);
        ttc_resync = 1'b1;
        tick();
        ttc_resync = 1'b0;
        repeat (GOOD_FRAMES) begin rand_data(); tick(); end
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < NCH; c++) delay_is[c*DLYW +: DLYW] = DLYW'(dl[k]);
            rx_data = '0;
            for (int i = 0; i < DEPTH + 1; i++) begin
                tick();
                n_checks++;
                if (data_out !== exp_data) begin n_fail++; $display("FAIL sweep flush d=%0d: got %h want %h", dl[k], data_out, exp_data); end
            end
            for (int c = 0; c < NCH; c++) pulse[c*DW +: DW] = one << ((c * 5 + k) % DW);
            rx_data = pulse;
            tick();
            rx_data = '0;
            lat = 1;
            while (data_out === '0 && lat < 40) begin tick(); lat++; end
            n_checks++;
            if (lat !== dl[k] + 1) begin n_fail++; $display("FAIL sweep latency d=%0d: got %0d want %0d", dl[k], lat, dl[k] + 1); end
            n_checks++;
            if (data_out !== pulse) begin n_fail++; $display("FAIL sweep pulse d=%0d: got %h want %h", dl[k], data_out, pulse); end
            for (int t = 0; t < 24; t++) begin
                for (int c = 0; c < NCH; c++) rx_data[c*DW +: DW] = one << ((t + c) % DW);
                tick();
                n_checks++;
                if (data_out !== exp_data) begin n_fail++; $display("FAIL sweep walk d=%0d: got %h want %h", dl[k], data_out, exp_data); end
            end
        end
    endtask

    task automatic test_async_reset();
        rx_match = '1;
        repeat (10) begin rand_data(); tick(); end
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({link_good, link_bad, link_had_err, any_bad} !== '0) begin
            n_fail++; $display("FAIL async_reset flags: got %h want 0", {link_good, link_bad, link_had_err, any_bad});
        end
        n_checks++;
        if (data_out !== '0 || err_count !== '0) begin
            n_fail++; $display("FAIL async_reset data/count: got %h/%h want 0", data_out, err_count);
        end
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        int c0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                rx_ready[c]    = $urandom_range(0, 99) != 0;
                rx_valid[c]    = $urandom_range(0, 9) < 8;
                rx_match[c]    = $urandom_range(0, 99) >= 4;
                rx_code_err[c] = $urandom_range(0, 99) < 2;
            end
            ttc_resync = $urandom_range(0, 149) == 0;
            if ($urandom_range(0, 31) == 0) begin
                c0 = $urandom_range(0, NCH - 1);
                delay_is[c0*DLYW +: DLYW] = DLYW'($urandom_range(0, DEPTH - 1));
            end
            rand_data();
            tick();
            n_checks++;
            if ({link_good, link_bad, link_had_err, any_bad} !== exp_flags()) begin
                n_fail++; $display("FAIL random flags n=%0d: got %h want %h", n, {link_good, link_bad, link_had_err, any_bad}, exp_flags());
            end
            n_checks++;
            if (err_count !== exp_cnt()) begin n_fail++; $display("FAIL random err_count n=%0d: got %h want %h", n, err_count, exp_cnt()); end
            n_checks++;
            if (data_out !== exp_data) begin n_fail++; $display("FAIL random data_out n=%0d: got %h want %h", n, data_out, exp_data); end
        end
        ttc_resync = 1'b0;
    endtask

    initial begin
        test_reset();
        test_link_up();
        test_bad_link();
        test_saturate();
        test_resync_drop();
        test_window_wrap();
        test_delay_sweep();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
